// File: rtl/av_counter_mod_n.sv
// Parametrised mod-N up/down counter with parallel load, sticky wrap flag and C43-style CI/CO cascade.
// Optional cell timing model: define AV_CELL_DLY_EN to add T_CKQ/T_CLQ/T_CO output delays.
`timescale 1ns/1ps
module av_counter_mod_n #(
    parameter int  WIDTH   = 8,
    parameter int  MODULUS = 256,
    parameter real T_CKQ   = 8.37,
    parameter real T_CLQ   = 5.54,
    parameter real T_CO    = 4.07
) (
    input  logic             CK,
    input  logic             CLn,
    input  logic             Ln,
    input  logic             CI,
    input  logic             EN,
    input  logic             UD,
    input  logic [WIDTH-1:0] D,
    input  logic             OVF_CLR,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             OVF
);

    if (WIDTH < 2 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("av_counter_mod_n: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
    end
    if (T_CKQ < 0.0 || T_CLQ < 0.0 || T_CO < 0.0) begin : g_bad_delay
        $error("av_counter_mod_n: cell delays must be non-negative");
    end

    localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             at_top, at_bot, step, wrap, co_d;

    always_comb begin
        // Out-of-range values (loaded D >= MODULUS) count as "at top" so up-counting recovers to 0.
        at_top = (q_q >= TERM);
        at_bot = (q_q == '0);
        step   = CI & EN;
        wrap   = Ln & step & (UD ? at_top : at_bot);
        co_d   = CI & (UD ? at_top : at_bot);
        q_d    = q_q;
        ovf_d  = ovf_q;
        if (!Ln) begin
            q_d = D;
        end else if (step) begin
            if (UD) begin
                q_d = at_top ? '0 : q_q + ONE;
            end else begin
                q_d = at_bot ? TERM : q_q - ONE;
            end
        end
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (OVF_CLR) begin
            ovf_d = 1'b0;
        end
    end

`ifdef AV_CELL_DLY_EN
    always_ff @(posedge CK or negedge CLn) begin
        if (!CLn) begin
            q_q   <= #(T_CLQ) '0;
            ovf_q <= #(T_CLQ) 1'b0;
        end else begin
            q_q   <= #(T_CKQ) q_d;
            ovf_q <= #(T_CKQ) ovf_d;
        end
    end

    assign #(T_CO) CO = co_d;
`else
    always_ff @(posedge CK or negedge CLn) begin
        if (!CLn) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign CO = co_d;
`endif

    assign Q   = q_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_av_counter_mod_n.sv
// Bench for av_counter_mod_n: WIDTH=4/MODULUS=10 counter against a behavioural model,
// directed cases with literal expectations, randomized traffic, and a two-stage mod-16 cascade.
`timescale 1ns/1ps
module tb_av_counter_mod_n;

    localparam int W = 4;
    localparam int M = 10;

    logic         CK = 1'b0;
    logic         CLn = 1'b0;
    logic         Ln = 1'b1, CI = 1'b0, EN = 1'b0, UD = 1'b1, OVF_CLR = 1'b0;
    logic [W-1:0] D = '0;
    logic [W-1:0] Q;
    logic         CO, OVF;

    logic         c_ln = 1'b1, c_ci = 1'b0, c_en = 1'b0, c_ud = 1'b1;
    logic [3:0]   c_d1 = '0, c_d2 = '0;
    logic [3:0]   cq1, cq2;
    logic         cco1, cco2, covf1, covf2;

    int n_chk  = 0;
    int n_pass = 0;
    int q_m    = 0;
    int ovf_m  = 0;
    bit cmp_en = 1'b0;

    always #5 CK = ~CK;

    av_counter_mod_n #(.WIDTH(W), .MODULUS(M)) dut (
        .CK(CK), .CLn(CLn), .Ln(Ln), .CI(CI), .EN(EN), .UD(UD), .D(D),
        .OVF_CLR(OVF_CLR), .Q(Q), .CO(CO), .OVF(OVF)
    );

    av_counter_mod_n #(.WIDTH(4), .MODULUS(16)) u_lo (
        .CK(CK), .CLn(CLn), .Ln(c_ln), .CI(c_ci), .EN(c_en), .UD(c_ud), .D(c_d1),
        .OVF_CLR(1'b0), .Q(cq1), .CO(cco1), .OVF(covf1)
    );

    av_counter_mod_n #(.WIDTH(4), .MODULUS(16)) u_hi (
        .CK(CK), .CLn(CLn), .Ln(c_ln), .CI(cco1), .EN(c_en), .UD(c_ud), .D(c_d2),
        .OVF_CLR(1'b0), .Q(cq2), .CO(cco2), .OVF(covf2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: counter value and wrap flag as plain integers.
    always @(posedge CK or negedge CLn) begin
        bit wrap;
        if (!CLn) begin
            q_m   = 0;
            ovf_m = 0;
        end else begin
            wrap = 1'b0;
            if (!Ln) begin
                q_m = int'(D);
            end else if (CI && EN) begin
                if (UD) begin
                    wrap = (q_m >= M - 1);
                    q_m  = wrap ? 0 : q_m + 1;
                end else begin
                    wrap = (q_m == 0);
                    q_m  = wrap ? M - 1 : q_m - 1;
                end
            end
            if (wrap) ovf_m = 1;
            else if (OVF_CLR) ovf_m = 0;
        end
    end

    always @(negedge CK) begin
        if (cmp_en) begin
            chk("model_Q", int'(Q), q_m);
            chk("model_OVF", int'(OVF), ovf_m);
            chk("model_CO", int'(CO), int'(CI && (UD ? (q_m >= M - 1) : (q_m == 0))));
        end
    end

    task automatic edge_();
        @(posedge CK);
        #1;
    endtask

    task automatic pulse_reset();
        #1 CLn = 1'b0;
        #1 CLn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seq1[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

        // Reset state
        CI = 1'b1; UD = 1'b0;
        edge_();
        edge_();
        chk("rst_Q", int'(Q), 0);
        chk("rst_OVF", int'(OVF), 0);
        chk("rst_CO", int'(CO), 1);
        cmp_en = 1'b1;

        // 1: count up through the wrap
        CLn = 1'b1; CI = 1'b1; EN = 1'b1; UD = 1'b1;
        for (int i = 0; i < 12; i++) begin
            edge_();
            chk("t1_Q", int'(Q), seq1[i]);
            chk("t1_OVF", int'(OVF), (i >= 9) ? 1 : 0);
            chk("t1_CO", int'(CO), (i == 8) ? 1 : 0);
        end

        // 2: count down from zero
        pulse_reset();
        UD = 1'b0;
        #1 chk("t2_CO_at0", int'(CO), 1);
        edge_();
        chk("t2_Q", int'(Q), 9);
        chk("t2_OVF", int'(OVF), 1);

        // 3: load wins over count, out-of-range value recovers to 0
        pulse_reset();
        UD = 1'b1; Ln = 1'b0; D = 4'd13;
        edge_();
        chk("t3_load_Q", int'(Q), 13);
        chk("t3_load_OVF", int'(OVF), 0);
        chk("t3_CO_oor", int'(CO), 1);
        Ln = 1'b1;
        edge_();
        chk("t3_Q", int'(Q), 0);
        chk("t3_OVF", int'(OVF), 1);

        // 4: set beats clear on a wrap edge
        Ln = 1'b0; D = 4'd9;
        edge_();
        chk("t4_load_OVF", int'(OVF), 1);
        Ln = 1'b1; OVF_CLR = 1'b1;
        edge_();
        chk("t4_wrap_Q", int'(Q), 0);
        chk("t4_wrap_OVF", int'(OVF), 1);
        edge_();
        chk("t4_clr_Q", int'(Q), 1);
        chk("t4_clr_OVF", int'(OVF), 0);
        OVF_CLR = 1'b0;

        // 5: asynchronous clear mid-count
        Ln = 1'b0; D = 4'd9;
        edge_();
        Ln = 1'b1;
        for (int i = 0; i < 7; i++) edge_();
        chk("t5_pre_Q", int'(Q), 6);
        chk("t5_pre_OVF", int'(OVF), 1);
        #1 CLn = 1'b0;
        #1 chk("t5_clr_Q", int'(Q), 0);
        chk("t5_clr_OVF", int'(OVF), 0);
        chk("t5_clr_CO_up", int'(CO), 0);
        UD = 1'b0;
        #1 chk("t5_clr_CO_dn", int'(CO), 1);
        CLn = 1'b1; UD = 1'b1;
        edge_();
        chk("t5_post_Q", int'(Q), 1);

        // 6: two mod-16 stages cascaded through CO->CI
        c_ln = 1'b0; c_d2 = 4'h0; c_d1 = 4'hF; c_ci = 1'b1; c_en = 1'b1; c_ud = 1'b1;
        edge_();
        chk("t6_load0F", int'({cq2, cq1}), 'h0F);
        c_ln = 1'b1;
        edge_();
        chk("t6_step10", int'({cq2, cq1}), 'h10);
        chk("t6_ovf_hi0", int'(covf2), 0);
        c_ln = 1'b0; c_d2 = 4'hF; c_d1 = 4'hF;
        edge_();
        chk("t6_chain_CO", int'(cco2), 1);
        c_ln = 1'b1;
        edge_();
        chk("t6_step00", int'({cq2, cq1}), 'h00);
        chk("t6_ovf_hi1", int'(covf2), 1);
        c_en = 1'b0;

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 400; i++) begin
            Ln      = ($urandom_range(0, 9) != 0);
            CI      = ($urandom_range(0, 5) != 0);
            EN      = ($urandom_range(0, 4) != 0);
            UD      = $urandom_range(0, 1) == 1;
            D       = W'($urandom_range(0, 15));
            OVF_CLR = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 39) == 0) pulse_reset();
            edge_();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
